// File: rtl/counter_pkg.sv
// counter_pkg: direction and wrap/saturate mode constants shared by the counter files
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/counter_next_step.sv
// counter_next_step: next count, range-end flag and clamped load value (in q/up/load_val, out step_q/at_end/load_q)
module counter_next_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] step_q,
  output logic             at_end,
  output logic [WIDTH-1:0] load_q
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  always_comb begin
    at_end = (up == DIR_UP) ? (q == MAX) : (q == '0);
    step_q = !at_end ? ((up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1)) :
             (SATURATE == MODE_SAT) ? q : ((up == DIR_UP) ? '0 : MAX);
    load_q = (load_val > MAX) ? MAX : load_val;
  end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: mod-N up/down counter (in clk/rst/en/up/load/load_val, out Q/tc/ovf)
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] load_q;
  logic             at_end;
  counter_next_step #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(SATURATE)) u_step (
    .q(Q),
    .up(up),
    .load_val(load_val),
    .step_q(step_q),
    .at_end(at_end),
    .load_q(load_q)
  );
  assign tc = en & at_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      Q <= load_q;
      ovf <= 1'b0;
    end else if (en) begin
      Q <= step_q;
      ovf <= at_end;
    end else begin
      ovf <= 1'b0;
    end
  end
endmodule
